// File: rtl/dest_reg_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : dest_reg_pipeline
//  Purpose  : Chooses the register-file destination (Rt, Rd or the link
//             register) and carries it, together with its write enable,
//             through a configurable chain of pipeline stages. Stall and
//             flush act on the chain. Combinational forwarding selects for the
//             two decode-stage source registers come from the destinations
//             currently in flight.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W   register address width
//    STAGES   pipeline depth (1..8); stage 1 is youngest, stage STAGES
//             drives the write port
//    LINK_REG destination used for link writes
//    SEL_W    width of the forwarding selects, clog2(STAGES+1)
//  Ports
//    clk          in   clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    RegDst       in   0 = Rt, 1 = Rd, 2 = LINK_REG, 3 = reserved (no write)
//    Rt, Rd       in   instruction destination fields
//    RegWrite_in  in   decode-stage write enable
//    Stall        in   hold every stage
//    Flush        in   load a bubble into stage 1 (wins over Stall)
//    RsDec, RtDec in   decode-stage source registers
//    WriteReg     out  stage STAGES destination
//    RegWrite_out out  stage STAGES write valid
//    FwdA, FwdB   out  youngest matching stage index, 0 when none
// ============================================================================
module dest_reg_pipeline #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned STAGES   = 3,
   parameter int unsigned LINK_REG = 31,
   parameter int unsigned SEL_W    = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        RegDst,
   input  logic [ADDR_W-1:0] Rt,
   input  logic [ADDR_W-1:0] Rd,
   input  logic              RegWrite_in,
   input  logic              Stall,
   input  logic              Flush,
   input  logic [ADDR_W-1:0] RsDec,
   input  logic [ADDR_W-1:0] RtDec,
   output logic [ADDR_W-1:0] WriteReg,
   output logic              RegWrite_out,
   output logic [SEL_W-1:0]  FwdA,
   output logic [SEL_W-1:0]  FwdB
);

   localparam logic [ADDR_W-1:0] c_LINK_ADDR = ADDR_W'(LINK_REG);
   localparam logic [1:0]        c_DST_RT    = 2'd0;
   localparam logic [1:0]        c_DST_RD    = 2'd1;
   localparam logic [1:0]        c_DST_LINK  = 2'd2;
   localparam logic [1:0]        c_DST_NONE  = 2'd3;

   // Index 0 holds stage 1 (youngest), index STAGES-1 holds the write stage.
   logic [ADDR_W-1:0] dest_q  [STAGES];
   logic [ADDR_W-1:0] dest_d  [STAGES];
   logic              valid_q [STAGES];
   logic              valid_d [STAGES];

   logic [ADDR_W-1:0] sel_dest;
   logic              sel_valid;

   // ------------------------------------------------------------------
   // Destination select. The reserved encoding carries address 0 so it
   // can never look like a real destination downstream.
   // ------------------------------------------------------------------
   always_comb begin
      sel_dest = '0;
      case (RegDst)
         c_DST_RT:   sel_dest = Rt;
         c_DST_RD:   sel_dest = Rd;
         c_DST_LINK: sel_dest = c_LINK_ADDR;
         default:    sel_dest = '0;
      endcase
      // Writes to $0 are architecturally discarded, so never mark them valid.
      sel_valid = RegWrite_in && (RegDst != c_DST_NONE) && (sel_dest != '0);
   end

   // ------------------------------------------------------------------
   // Next-state for the stage chain.
   // Stage 1: Flush forces a bubble even while stalled; otherwise it loads
   // the new destination unless stalled. Older stages simply follow Stall.
   // ------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         dest_d[k]  = dest_q[k];
         valid_d[k] = valid_q[k];
      end

      if (Flush) begin
         dest_d[0]  = '0;
         valid_d[0] = 1'b0;
      end else if (!Stall) begin
         dest_d[0]  = sel_dest;
         valid_d[0] = sel_valid;
      end

      if (!Stall) begin
         for (int k = 1; k < int'(STAGES); k++) begin
            dest_d[k]  = dest_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            dest_q[k]  <= '0;
            valid_q[k] <= 1'b0;
         end
      end else begin
         dest_q  <= dest_d;
         valid_q <= valid_d;
      end
   end

   assign WriteReg     = dest_q[STAGES-1];
   assign RegWrite_out = valid_q[STAGES-1];

   // ------------------------------------------------------------------
   // Forwarding selects. Scanning from oldest to youngest lets the
   // youngest match overwrite older ones, giving it priority.
   // ------------------------------------------------------------------
   always_comb begin
      FwdA = '0;
      FwdB = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         if (valid_q[k] && (dest_q[k] == RsDec) && (RsDec != '0)) begin
            FwdA = SEL_W'(k + 1);
         end
         if (valid_q[k] && (dest_q[k] == RtDec) && (RtDec != '0)) begin
            FwdB = SEL_W'(k + 1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dest_reg_pipeline.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dest_reg_pipeline
//  Purpose  : Self-checking bench for dest_reg_pipeline at depths 1, 3 and 5,
//             all three sharing the same stimulus. A history queue of the
//             captured destinations serves as the scoreboard; fixed vectors
//             and short hand sequences check the named corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dest_reg_pipeline;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] RegDst;
   logic [4:0] Rt, Rd, RsDec, RtDec;
   logic       RegWrite_in, Stall, Flush;

   logic [4:0] wr1, wr3, wr5;
   logic       we1, we3, we5;
   logic [0:0] fa1, fb1;
   logic [1:0] fa3, fb3;
   logic [2:0] fa5, fb5;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dest_reg_pipeline #(.STAGES(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .Rt(Rt), .Rd(Rd),
      .RegWrite_in(RegWrite_in), .Stall(Stall), .Flush(Flush),
      .RsDec(RsDec), .RtDec(RtDec), .WriteReg(wr1), .RegWrite_out(we1),
      .FwdA(fa1), .FwdB(fb1));

   dest_reg_pipeline #(.STAGES(3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .Rt(Rt), .Rd(Rd),
      .RegWrite_in(RegWrite_in), .Stall(Stall), .Flush(Flush),
      .RsDec(RsDec), .RtDec(RtDec), .WriteReg(wr3), .RegWrite_out(we3),
      .FwdA(fa3), .FwdB(fb3));

   dest_reg_pipeline #(.STAGES(5)) u_s5 (
      .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .Rt(Rt), .Rd(Rd),
      .RegWrite_in(RegWrite_in), .Stall(Stall), .Flush(Flush),
      .RsDec(RsDec), .RtDec(RtDec), .WriteReg(wr5), .RegWrite_out(we5),
      .FwdA(fa5), .FwdB(fb5));

   // ------------------------------------------------------------------
   // Scoreboard: every captured entry is pushed in capture order; stage k
   // of any depth is the k-th most recent entry (bubble if none yet).
   // dc marks reserved-select entries whose address is left undefined.
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [4:0] d;
      logic       v;
      logic       dc;
   } ent_t;

   localparam ent_t c_BUB = '{d: 5'd0, v: 1'b0, dc: 1'b0};

   ent_t hist[$];

   function automatic ent_t sel_ent();
      ent_t e;
      e = c_BUB;
      case (RegDst)
         2'd0: e.d = Rt;
         2'd1: e.d = Rd;
         2'd2: e.d = 5'd31;
         default: begin e.d = 5'd0; e.dc = 1'b1; end
      endcase
      e.v = RegWrite_in && (RegDst != 2'd3) && (e.d != 5'd0);
      return e;
   endfunction

   function automatic ent_t stage(int k);
      int i;
      i = hist.size() - k;
      if (i < 0) return c_BUB;
      return hist[i];
   endfunction

   function automatic int model_fwd(int n, logic [4:0] src);
      ent_t e;
      for (int k = 1; k <= n; k++) begin
         e = stage(k);
         if (e.v && e.d == src && src != 5'd0) return k;
      end
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist.delete();
      end else if (Flush && Stall) begin
         if (hist.size() > 0) hist[hist.size()-1] = c_BUB;
      end else if (!Stall) begin
         if (Flush) hist.push_back(c_BUB);
         else       hist.push_back(sel_ent());
         if (hist.size() > 16) void'(hist.pop_front());
      end
   end

   task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_dut(string n, int depth, logic [31:0] wr, logic [31:0] we,
                          logic [31:0] fa, logic [31:0] fb);
      ent_t e;
      e = stage(depth);
      cmp({n, ".RegWrite_out"}, we, 32'(e.v));
      if (!e.dc) cmp({n, ".WriteReg"}, wr, 32'(e.d));
      cmp({n, ".FwdA"}, fa, 32'(model_fwd(depth, RsDec)));
      cmp({n, ".FwdB"}, fb, 32'(model_fwd(depth, RtDec)));
   endtask

   task automatic check_all();
      chk_dut("s1", 1, 32'(wr1), 32'(we1), 32'(fa1), 32'(fb1));
      chk_dut("s3", 3, 32'(wr3), 32'(we3), 32'(fa3), 32'(fb3));
      chk_dut("s5", 5, 32'(wr5), 32'(we5), 32'(fa5), 32'(fb5));
   endtask

   // One rising edge, then compare everything on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic issue(logic [1:0] sel, logic [4:0] t, logic we);
      RegDst      = sel;
      Rt          = t;
      RegWrite_in = we;
      cyc();
   endtask

   typedef struct {
      logic [1:0] sel;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       we;
      logic [4:0] exp_d;
      logic       exp_v;
      logic       chk_d;
   } vec_t;

   vec_t vecs[7];

   task automatic vcheck(string n, int i, logic [4:0] wr, logic we);
      cmp($sformatf("%s.vec%0d.valid", n, i), 32'(we), 32'(vecs[i].exp_v));
      if (vecs[i].chk_d) cmp($sformatf("%s.vec%0d.dest", n, i), 32'(wr), 32'(vecs[i].exp_d));
   endtask

   initial begin
      logic [4:0] snap_wr3, snap_wr5;
      logic       snap_we3, snap_we5;

      vecs[0] = '{2'd0, 5'd8, 5'd9, 1'b1, 5'd8,  1'b1, 1'b1};
      vecs[1] = '{2'd1, 5'd8, 5'd9, 1'b1, 5'd9,  1'b1, 1'b1};
      vecs[2] = '{2'd2, 5'd8, 5'd9, 1'b1, 5'd31, 1'b1, 1'b1};
      vecs[3] = '{2'd0, 5'd0, 5'd9, 1'b1, 5'd0,  1'b0, 1'b1};
      vecs[4] = '{2'd3, 5'd8, 5'd9, 1'b1, 5'd0,  1'b0, 1'b0};
      vecs[5] = '{2'd1, 5'd4, 5'd0, 1'b1, 5'd0,  1'b0, 1'b1};
      vecs[6] = '{2'd0, 5'd8, 5'd9, 1'b0, 5'd8,  1'b0, 1'b1};

      rst_n = 1'b0; RegDst = 2'd0; Rt = '0; Rd = '0; RegWrite_in = 1'b0;
      Stall = 1'b0; Flush = 1'b0; RsDec = '0; RtDec = '0;
      repeat (2) @(negedge clk);
      cmp("reset.s3.RegWrite_out", 32'(we3), 0);
      cmp("reset.s5.WriteReg", 32'(wr5), 0);
      check_all();
      rst_n = 1'b1;

      // Select and latency vectors: depth N shows the entry after edge N.
      for (int i = 0; i < 7; i++) begin
         RegDst = vecs[i].sel; Rt = vecs[i].rt; Rd = vecs[i].rd;
         RegWrite_in = vecs[i].we;
         cyc();
         vcheck("s1", i, wr1, we1);
         RegWrite_in = 1'b0;
         cyc(); cyc();
         vcheck("s3", i, wr3, we3);
         cyc(); cyc();
         vcheck("s5", i, wr5, we5);
      end

      // Forwarding priority: youngest match wins.
      Rd = 5'd0;
      issue(2'd0, 5'd5, 1'b1);
      issue(2'd0, 5'd5, 1'b1);
      RsDec = 5'd5; #1;
      cmp("fwd.s1.young", 32'(fa1), 1);
      cmp("fwd.s3.young", 32'(fa3), 1);
      cmp("fwd.s5.young", 32'(fa5), 1);
      issue(2'd0, 5'd5, 1'b0);
      cmp("fwd.s1.bubble", 32'(fa1), 0);
      cmp("fwd.s3.bubble", 32'(fa3), 2);
      cmp("fwd.s5.bubble", 32'(fa5), 2);
      issue(2'd0, 5'd5, 1'b0);
      cmp("fwd.s3.oldest", 32'(fa3), 3);
      RtDec = 5'd5; #1;
      cmp("fwd.s5.B", 32'(fb5), 3);
      RsDec = 5'd0; #1;
      cmp("fwd.s3.zero", 32'(fa3), 0);
      cmp("fwd.s5.zero", 32'(fa5), 0);
      RtDec = 5'd0;

      // Stall held four cycles: outputs frozen.
      issue(2'd0, 5'd20, 1'b1);
      issue(2'd0, 5'd21, 1'b1);
      issue(2'd0, 5'd22, 1'b1);
      snap_wr3 = wr3; snap_we3 = we3; snap_wr5 = wr5; snap_we5 = we5;
      Stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(2'd0, 5'(23 + i), 1'b1);
         cmp("stall.s3.WriteReg", 32'(wr3), 32'(snap_wr3));
         cmp("stall.s3.RegWrite_out", 32'(we3), 32'(snap_we3));
         cmp("stall.s5.WriteReg", 32'(wr5), 32'(snap_wr5));
         cmp("stall.s5.RegWrite_out", 32'(we5), 32'(snap_we5));
      end
      Stall = 1'b0;
      cmp("stall.s3.held", 32'(wr3), 20);

      // Stall together with Flush: only stage 1 becomes a bubble.
      issue(2'd0, 5'd10, 1'b1);
      issue(2'd0, 5'd11, 1'b1);
      issue(2'd0, 5'd12, 1'b1);
      Stall = 1'b1; Flush = 1'b1;
      issue(2'd0, 5'd13, 1'b1);
      RsDec = 5'd12; #1;
      cmp("sflush.s3.fwd12", 32'(fa3), 0);
      RsDec = 5'd11; #1;
      cmp("sflush.s3.fwd11", 32'(fa3), 2);
      cmp("sflush.s3.WriteReg", 32'(wr3), 10);
      cmp("sflush.s3.RegWrite_out", 32'(we3), 1);
      Stall = 1'b0; Flush = 1'b0;
      issue(2'd0, 5'd14, 1'b1);
      cmp("sflush.s3.resume11", 32'(wr3), 11);
      issue(2'd0, 5'd15, 1'b0);
      cmp("sflush.s3.bubble", 32'(we3), 0);
      issue(2'd0, 5'd15, 1'b0);
      cmp("sflush.s3.resume14", 32'(wr3), 14);
      cmp("sflush.s3.valid14", 32'(we3), 1);

      // Randomised traffic against the scoreboard.
      for (int i = 0; i < 300; i++) begin
         RegDst      = 2'($urandom_range(0, 3));
         Rt          = 5'($urandom_range(0, 7));
         Rd          = 5'($urandom_range(0, 7));
         RegWrite_in = 1'($urandom_range(0, 3) != 0);
         Stall       = ($urandom_range(0, 4) == 0);
         Flush       = ($urandom_range(0, 9) == 0);
         RsDec       = 5'($urandom_range(0, 7));
         RtDec       = 5'($urandom_range(0, 7));
         cyc();
      end

      // Asynchronous reset with writes in flight.
      Stall = 1'b0; Flush = 1'b0; RsDec = 5'd7; RtDec = 5'd7;
      for (int i = 0; i < 5; i++) issue(2'd0, 5'd7, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      cmp("arst.s1.RegWrite_out", 32'(we1), 0);
      cmp("arst.s3.RegWrite_out", 32'(we3), 0);
      cmp("arst.s5.RegWrite_out", 32'(we5), 0);
      cmp("arst.s3.WriteReg", 32'(wr3), 0);
      cmp("arst.s5.WriteReg", 32'(wr5), 0);
      cmp("arst.s3.FwdA", 32'(fa3), 0);
      cmp("arst.s5.FwdB", 32'(fb5), 0);
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      issue(2'd1, 5'd0, 1'b1);
      issue(2'd0, 5'd0, 1'b0);
      issue(2'd0, 5'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
